spi_master_ctrl: RTL
====================

// Module: spi_master_ctrl
// PURPOSE
// SPI initiator for the SPI peripheral memory: drives cs/sclk/mosi, samples miso.
// One request = one 16-bit frame: byte 0 = {addr[6:0], rw}, byte 1 = data (MSB first).
// rw=0 writes wdata to peripheral memory; rw=1 reads a byte into rdata.
// Mode 0: sclk idles low; peripheral samples on sclk rise; mosi changes after sclk fall.
// PARAMETERS
// CLKDIV   4   clk cycles per sclk half-period; legal range >= 2
// ADDR_W   7   address bits in byte 0 (ADDR_W+1 must equal DATA_W)
// DATA_W   8   data bits per frame
// PORTS
// clk    in   1       system clock, all logic on posedge
// rst_n  in   1       asynchronous, active-low reset
// start  in   1       request strobe; sampled only when busy=0
// rw     in   1       0=write, 1=read; captured with start
// addr   in   ADDR_W  peripheral address; captured with start
// wdata  in   DATA_W  write data; captured with start
// busy   out  1       high from cycle after accepted start until done cycle
// done   out  1       one-cycle pulse, end of frame
// rdata  out  DATA_W  read result; updated only at done of read frames
// cs     out  1       chip select, active low
// sclk   out  1       serial clock
// mosi   out  1       serial data to peripheral
// miso   in   1       serial data from peripheral
// BEHAVIOUR
// - Reset (async, immediate): cs=1, sclk=0, mosi=0, busy=0, done=0, rdata=0, state=IDLE.
// - All outputs registered; no combinational path from inputs to outputs.
// - start while busy=1 ignored; start+rw/addr/wdata captured into 16-bit tx shreg.
// - States: IDLE -> SETUP -> SHIFT -> GUARD -> IDLE.
// - IDLE: cs=1, sclk=0. start=1 -> cycle+1: cs=0, busy=1, mosi=tx[15], enter SETUP.
// - SETUP: CLKDIV cycles, sclk low, mosi stable (setup time before first rise).
// - SHIFT: 16 bits, each = CLKDIV high + CLKDIV low; bit index 15..0.
//   On sclk fall: shift tx, mosi=next bit; after bit 0 fall mosi=0.
//   Read frame, data phase (bits 7..0): mosi driven 0; miso sampled on the clk
//   cycle sclk goes high, shifted into rx shreg MSB first.
//   Write frame: mosi=wdata bits in data phase; miso ignored.
// - After last low half (bit 0) -> cs=1, enter GUARD (cs low total = 33*CLKDIV cycles).
// - GUARD: CLKDIV cycles cs=1, sclk=0 (lets peripheral reset to address phase).
//   Last GUARD cycle -> next cycle done=1, busy=0, rdata<=rx if read; state IDLE.
// - Start in the done cycle is accepted (back-to-back frames; guard still applies).
// - Exactly 16 sclk rising edges per frame; never a partial frame except via reset.
// - Reset mid-frame: cs rises asynchronously, no done pulse, rdata keeps reset value 0.
// - Half-period counter: $clog2(CLKDIV) bits, reloads at CLKDIV-1, wraps to 0.
// - Bit counter: 4 bits, 15 down to 0; underflow never reached (exit at 0).
// STRUCTURE
// - Shared header spi_defs.vh: state encodings, `RW_READ 1'b1 / `RW_WRITE 1'b0,
//   FRAME_BITS=16, ADDR_W/DATA_W defaults; shared with the peripheral-side logic.
// - One sub-module: spi_half_tick (CLKDIV counter, enable, one-cycle half-period tick).
// - Top: FSM, bit counter, tx/rx shift registers, output registers.
// TESTING
// - Write addr=7'h2A, wdata=8'hC3, CLKDIV=4: mosi over 16 rises = 0x54C3; cs low 132 cycles, done 4 cycles after cs rise.
// - Read addr=7'h05 with model returning 8'h96 on miso: mosi byte0=0x0B, byte1=0x00; rdata=8'h96 at done.
// - start pulsed mid-frame with different addr: ignored; frame unchanged; busy stays 1.
// - Back-to-back: start held high through done: second frame starts next cycle, cs high >= 4 cycles between.
// - rst_n low at bit 9: cs=1, sclk=0 same cycle; no done; next start yields clean full frame.
// - CLKDIV=2 against peripheral lute + memory: write 8'h5A to 7'h10, read back 8'h5A.

Source files
------------

// File: rtl/spi_master_ctrl_pkg.sv
// Shared definitions for the SPI initiator: frame geometry, rw encodings and FSM states.
package spi_master_ctrl_pkg;

  localparam int unsigned FrameBits = 16;
  localparam int unsigned AddrWDef  = 7;
  localparam int unsigned DataWDef  = 8;

  localparam logic RwWrite = 1'b0;
  localparam logic RwRead  = 1'b1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSetup = 2'd1,
    StShift = 2'd2,
    StGuard = 2'd3
  } state_e;

endpackage

// File: rtl/spi_master_ctrl_half_tick.sv
// Half-period timer for the SPI initiator.
// Counts clk cycles while enabled and pulses o_tick on the last cycle of each
// CLKDIV-cycle half period. Held at zero while disabled so every frame starts aligned.
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   i_en     count enable (frame in progress)
//   o_tick   one-cycle pulse on the final cycle of a half period
module spi_master_ctrl_half_tick #(
  parameter int unsigned CLKDIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned CntW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKDIV - 1);

  logic [CntW-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == CntMax);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_en || (r_cnt == CntMax)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 initiator for the SPI peripheral memory.
// One request is one frame: byte 0 = {addr, rw}, byte 1 = data, MSB first.
// rw=0 writes i_wdata to the peripheral; rw=1 reads a byte back into o_rdata.
// Ports:
//   i_clk, i_rst_n   system clock, asynchronous active-low reset
//   i_start          request strobe, accepted only while idle
//   i_rw/i_addr/i_wdata  request fields, captured with i_start
//   o_busy           high from the cycle after accept until the done cycle
//   o_done           one-cycle pulse at end of frame
//   o_rdata          read result, updated only at done of read frames
//   o_cs/o_sclk/o_mosi  SPI outputs (cs active low), i_miso SPI input
module spi_master_ctrl
  import spi_master_ctrl_pkg::*;
#(
  parameter int unsigned CLKDIV = 4,
  parameter int unsigned ADDR_W = AddrWDef,
  parameter int unsigned DATA_W = DataWDef
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_rw,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_cs,
  output logic              o_sclk,
  output logic              o_mosi,
  input  logic              i_miso
);

  localparam int unsigned FrameW      = ADDR_W + 1 + DATA_W;
  localparam logic [3:0]  FirstBit    = 4'(FrameW - 1);
  localparam logic [3:0]  LastDataBit = 4'(DATA_W - 1);

  state_e              r_state, w_state_nxt;
  logic                r_cs, w_cs_nxt;
  logic                r_sclk, w_sclk_nxt;
  logic                r_mosi, w_mosi_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                r_rw, w_rw_nxt;
  logic [3:0]          r_bit, w_bit_nxt;
  // tx holds the bits still to be sent after the one currently on mosi
  logic [FrameW-2:0]   r_tx, w_tx_nxt;
  logic [DATA_W-1:0]   r_rx, w_rx_nxt;
  logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;

  logic                w_tick;
  logic [3:0]          w_bit_dec;
  logic [DATA_W-1:0]   w_load_data;

  spi_master_ctrl_half_tick #(
    .CLKDIV (CLKDIV)
  ) u_half_tick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (r_state != StIdle),
    .o_tick  (w_tick)
  );

  assign w_bit_dec   = r_bit - 4'd1;
  // Read frames send zeros in the data phase
  assign w_load_data = (i_rw == RwRead) ? '0 : i_wdata;

  always_comb begin
    w_state_nxt = r_state;
    w_cs_nxt    = r_cs;
    w_sclk_nxt  = r_sclk;
    w_mosi_nxt  = r_mosi;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_rw_nxt    = r_rw;
    w_bit_nxt   = r_bit;
    w_tx_nxt    = r_tx;
    w_rx_nxt    = r_rx;
    w_rdata_nxt = r_rdata;

    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_nxt = StSetup;
          w_cs_nxt    = 1'b0;
          w_busy_nxt  = 1'b1;
          w_rw_nxt    = i_rw;
          w_bit_nxt   = FirstBit;
          w_mosi_nxt  = i_addr[ADDR_W-1];
          w_tx_nxt    = {i_addr[ADDR_W-2:0], i_rw, w_load_data};
          w_rx_nxt    = '0;
        end
      end
      StSetup: begin
        if (w_tick) begin
          w_state_nxt = StShift;
          w_sclk_nxt  = 1'b1;
        end
      end
      StShift: begin
        if (w_tick) begin
          if (r_sclk) begin
            // Falling edge: present the next bit, or park mosi low after the last one
            w_sclk_nxt = 1'b0;
            w_tx_nxt   = {r_tx[FrameW-3:0], 1'b0};
            w_mosi_nxt = (r_bit == 4'd0) ? 1'b0 : r_tx[FrameW-2];
          end else if (r_bit == 4'd0) begin
            w_state_nxt = StGuard;
            w_cs_nxt    = 1'b1;
          end else begin
            // Rising edge of the next bit; miso has been stable since the last fall
            w_sclk_nxt = 1'b1;
            w_bit_nxt  = w_bit_dec;
            if ((r_rw == RwRead) && (w_bit_dec <= LastDataBit)) begin
              w_rx_nxt = {r_rx[DATA_W-2:0], i_miso};
            end
          end
        end
      end
      StGuard: begin
        if (w_tick) begin
          w_state_nxt = StIdle;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          if (r_rw == RwRead) begin
            w_rdata_nxt = r_rx;
          end
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_cs    <= 1'b1;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rw    <= RwWrite;
      r_bit   <= 4'd0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cs    <= w_cs_nxt;
      r_sclk  <= w_sclk_nxt;
      r_mosi  <= w_mosi_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_rw    <= w_rw_nxt;
      r_bit   <= w_bit_nxt;
      r_tx    <= w_tx_nxt;
      r_rx    <= w_rx_nxt;
      r_rdata <= w_rdata_nxt;
    end
  end

  assign o_cs    = r_cs;
  assign o_sclk  = r_sclk;
  assign o_mosi  = r_mosi;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_rdata = r_rdata;

endmodule
